instruction_decode: RTL
=======================

INSTRUCTION_DECODE -- requirements
Module: instruction_decode

Interface
REQ-001 SHALL have the following ports, clock and reset first (name, direction, width, meaning):
- i_clk  in  1  single clock; all state on rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_if_id_pc  in  32  PC from the IF/ID register.
- i_if_id_instruction  in  32  instruction from the IF/ID register.
- i_wb_we  in  1  writeback write enable.
- i_wb_rd  in  5  writeback destination register.
- i_wb_data  in  32  writeback data.
- i_flush  in  1  branch/jump taken in EX; squash the instruction in decode.
- o_stall  out  1  load-use hazard; PC and IF/ID hold.
- o_id_ex_pc, o_id_ex_rs1_data, o_id_ex_rs2_data, o_id_ex_imm  out  32 each  registered operands.
- o_id_ex_rs1, o_id_ex_rs2, o_id_ex_rd  out  5 each  register indices.
- o_id_ex_funct3  out  3; o_id_ex_funct7b5  out  1  (instruction bit 30).
- o_id_ex_reg_write, o_id_ex_mem_read, o_id_ex_mem_write, o_id_ex_mem_to_reg, o_id_ex_alu_src, o_id_ex_a_sel, o_id_ex_branch, o_id_ex_jump, o_id_ex_illegal  out  1 each  registered controls.
- o_id_ex_alu_op  out  2  00 add, 01 branch compare, 10 R-type, 11 I-ALU.

Function
REQ-002 Register file SHALL be 32x32; x0 SHALL always read 0; write on rising edge when i_wb_we=1 and i_wb_rd!=0.
REQ-003 Reads SHALL be combinational on instruction[19:15] and [24:20]; the ID/EX register SHALL capture on the next rising edge (latency 1 cycle).
REQ-004 Decode SHALL cover RV32I opcodes: R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
REQ-005 Immediate SHALL be sign-extended per format (I, S, B, U, J); B and J SHALL have bit 0 = 0; U SHALL be {inst[31:12], 12'b0}; R-type imm SHALL be 0.
REQ-006 Controls: LOAD = reg_write, mem_read, mem_to_reg, alu_src; STORE = mem_write, alu_src; BRANCH = branch, alu_op 01; JAL = jump, reg_write, a_sel; JALR = jump, reg_write, alu_src; LUI = reg_write, alu_src, rs1 forced to 0; AUIPC = reg_write, alu_src, a_sel.
REQ-007 Unknown opcode SHALL latch a bubble with o_id_ex_illegal=1 and o_id_ex_pc = i_if_id_pc.
REQ-008 Bubble SHALL mean all control outputs and o_id_ex_rd equal 0; data fields are don't-care but SHALL be driven to 0.
REQ-009 o_stall SHALL be 1 combinationally when o_id_ex_mem_read=1, o_id_ex_rd!=0, and o_id_ex_rd equals a source register used by the decoding instruction (rs2 unused for I-ALU, LOAD, JAL, JALR, LUI, AUIPC).
REQ-010 While o_stall=1, a bubble SHALL be latched into ID/EX; register file writes SHALL proceed.
REQ-011 i_flush=1 SHALL latch a bubble with o_id_ex_illegal=0 and force o_stall=0; flush SHALL have priority over stall and illegal.
REQ-012 A simultaneous writeback and read of the same register SHALL follow REQ-017.

Reset
REQ-013 While i_reset=1, all ID/EX outputs and all 32 registers SHALL be 0 asynchronously; o_stall SHALL be 0.
REQ-014 Reset asserted mid-operation SHALL discard the in-flight instruction; the first edge after deassertion SHALL decode normally.
REQ-015 A writeback coinciding with reset assertion SHALL be lost.

Configuration
REQ-016 Macro ID_WB_BYPASS_EN SHALL select the register file read policy.
REQ-017 With ID_WB_BYPASS_EN defined: when i_wb_we=1, i_wb_rd!=0 and i_wb_rd equals a source index, the read SHALL return i_wb_data in the same cycle. Without it: the read SHALL return the old value, and the new value SHALL be visible from the next cycle.

Verification
REQ-018 Bench SHALL cover:
- Reset, then write x5=0x12345678, then decode ADD x3,x5,x0 -> rs1_data=0x12345678, alu_op=10, reg_write=1.
- LW x7,-4(x2) followed by ADDI x8,x7,1 -> o_stall=1 for one cycle, then a bubble (reg_write=0, rd=0), then ADDI latched with imm=1.
- BEQ with offset -8 -> imm=0xFFFFFFF8, branch=1, alu_op=01; the same edge with i_flush=1 -> bubble with illegal=0.
- Writeback x9=0xDEADBEEF on the same cycle as a read of x9 -> 0xDEADBEEF with ID_WB_BYPASS_EN, old value without it.
- Write to x0 with 0xFFFFFFFF -> x0 still reads 0; opcode 0x7F -> illegal=1 and all controls 0.
- i_reset pulse between clock edges -> outputs 0 immediately, with no clock edge required.

Source files
------------

// File: rtl/instruction_decode.sv
// RV32I decode stage: 32x32 register file, immediate/control decode, load-use stall, ID/EX register.
// Define ID_WB_BYPASS_EN to forward same-cycle writeback data onto the register read ports.
module instruction_decode (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_if_id_pc,
    input  logic [31:0] i_if_id_instruction,
    input  logic        i_wb_we,
    input  logic [4:0]  i_wb_rd,
    input  logic [31:0] i_wb_data,
    input  logic        i_flush,
    output logic        o_stall,
    output logic [31:0] o_id_ex_pc,
    output logic [31:0] o_id_ex_rs1_data,
    output logic [31:0] o_id_ex_rs2_data,
    output logic [31:0] o_id_ex_imm,
    output logic [4:0]  o_id_ex_rs1,
    output logic [4:0]  o_id_ex_rs2,
    output logic [4:0]  o_id_ex_rd,
    output logic [2:0]  o_id_ex_funct3,
    output logic        o_id_ex_funct7b5,
    output logic        o_id_ex_reg_write,
    output logic        o_id_ex_mem_read,
    output logic        o_id_ex_mem_write,
    output logic        o_id_ex_mem_to_reg,
    output logic        o_id_ex_alu_src,
    output logic        o_id_ex_a_sel,
    output logic        o_id_ex_branch,
    output logic        o_id_ex_jump,
    output logic        o_id_ex_illegal,
    output logic [1:0]  o_id_ex_alu_op
);

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic        funct7b5;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic        alu_src;
        logic        a_sel;
        logic        branch;
        logic        jump;
        logic        illegal;
        logic [1:0]  alu_op;
    } id_ex_t;

    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];
    id_ex_t      id_ex_q, id_ex_d, dec;

    logic [31:0] inst;
    logic [6:0]  opcode;
    logic [4:0]  rs1_idx, rs2_idx;
    logic [31:0] rs1_rd, rs2_rd;
    logic        legal, use_rs1, use_rs2, stall;

    assign inst    = i_if_id_instruction;
    assign opcode  = inst[6:0];
    assign rs1_idx = (opcode == OpLui) ? 5'd0 : inst[19:15];
    assign rs2_idx = inst[24:20];

    always_comb begin
        regs_d = regs_q;
        if (i_wb_we && (i_wb_rd != 5'd0)) begin
            regs_d[i_wb_rd] = i_wb_data;
        end
    end

    // regs_q[0] is never written, so index 0 reads zero without a special case.
    always_comb begin
        rs1_rd = regs_q[rs1_idx];
        rs2_rd = regs_q[rs2_idx];
`ifdef ID_WB_BYPASS_EN
        if (i_wb_we && (i_wb_rd != 5'd0) && (i_wb_rd == rs1_idx)) rs1_rd = i_wb_data;
        if (i_wb_we && (i_wb_rd != 5'd0) && (i_wb_rd == rs2_idx)) rs2_rd = i_wb_data;
`endif
    end

    always_comb begin
        dec     = '0;
        legal   = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b0;
        unique case (opcode)
            OpR: begin
                dec.reg_write = 1'b1;
                dec.alu_op    = 2'b10;
                use_rs2       = 1'b1;
            end
            OpImm: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_op    = 2'b11;
                dec.imm       = {{20{inst[31]}}, inst[31:20]};
            end
            OpLoad: begin
                dec.reg_write  = 1'b1;
                dec.mem_read   = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.alu_src    = 1'b1;
                dec.imm        = {{20{inst[31]}}, inst[31:20]};
            end
            OpStore: begin
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.imm       = {{20{inst[31]}}, inst[31:25], inst[11:7]};
                use_rs2       = 1'b1;
            end
            OpBranch: begin
                dec.branch = 1'b1;
                dec.alu_op = 2'b01;
                dec.imm    = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
                use_rs2    = 1'b1;
            end
            OpJal: begin
                dec.jump      = 1'b1;
                dec.reg_write = 1'b1;
                dec.a_sel     = 1'b1;
                dec.imm       = {{11{inst[31]}}, inst[31], inst[19:12], inst[20],
                                 inst[30:21], 1'b0};
            end
            OpJalr: begin
                dec.jump      = 1'b1;
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.imm       = {{20{inst[31]}}, inst[31:20]};
            end
            OpLui: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.imm       = {inst[31:12], 12'b0};
            end
            OpAuipc: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.a_sel     = 1'b1;
                dec.imm       = {inst[31:12], 12'b0};
            end
            default: begin
                legal   = 1'b0;
                use_rs1 = 1'b0;
            end
        endcase
        dec.pc       = i_if_id_pc;
        dec.rs1      = rs1_idx;
        dec.rs2      = rs2_idx;
        dec.rs1_data = rs1_rd;
        dec.rs2_data = rs2_rd;
        dec.funct3   = inst[14:12];
        dec.funct7b5 = inst[30];
        // Only instructions that write a register expose a destination downstream.
        dec.rd       = dec.reg_write ? inst[11:7] : 5'd0;
    end

    always_comb begin
        stall = !i_flush && id_ex_q.mem_read && (id_ex_q.rd != 5'd0) &&
                ((use_rs1 && (id_ex_q.rd == rs1_idx)) ||
                 (use_rs2 && (id_ex_q.rd == rs2_idx)));
        id_ex_d = '0;
        if (i_flush || stall) begin
            id_ex_d = '0;
        end else if (!legal) begin
            id_ex_d.illegal = 1'b1;
            id_ex_d.pc      = i_if_id_pc;
        end else begin
            id_ex_d = dec;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
            id_ex_q <= '0;
        end else begin
            regs_q  <= regs_d;
            id_ex_q <= id_ex_d;
        end
    end

    assign o_stall            = stall;
    assign o_id_ex_pc         = id_ex_q.pc;
    assign o_id_ex_rs1_data   = id_ex_q.rs1_data;
    assign o_id_ex_rs2_data   = id_ex_q.rs2_data;
    assign o_id_ex_imm        = id_ex_q.imm;
    assign o_id_ex_rs1        = id_ex_q.rs1;
    assign o_id_ex_rs2        = id_ex_q.rs2;
    assign o_id_ex_rd         = id_ex_q.rd;
    assign o_id_ex_funct3     = id_ex_q.funct3;
    assign o_id_ex_funct7b5   = id_ex_q.funct7b5;
    assign o_id_ex_reg_write  = id_ex_q.reg_write;
    assign o_id_ex_mem_read   = id_ex_q.mem_read;
    assign o_id_ex_mem_write  = id_ex_q.mem_write;
    assign o_id_ex_mem_to_reg = id_ex_q.mem_to_reg;
    assign o_id_ex_alu_src    = id_ex_q.alu_src;
    assign o_id_ex_a_sel      = id_ex_q.a_sel;
    assign o_id_ex_branch     = id_ex_q.branch;
    assign o_id_ex_jump       = id_ex_q.jump;
    assign o_id_ex_illegal    = id_ex_q.illegal;
    assign o_id_ex_alu_op     = id_ex_q.alu_op;

endmodule
